// File: rtl/regfile_bram.sv
// Register file with registered dual read ports, one write port and a hard-wired zero
// register; a sequential clear engine zeroes the array. Optional macro: REGFILE_BYPASS_EN.
module regfile_bram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r_addr_reg1,
  output logic [DATA_W-1:0] r_data_reg1,
  input  logic [ADDR_W-1:0] r_addr_reg2,
  output logic [DATA_W-1:0] r_data_reg2,
  input  logic [ADDR_W-1:0] w_addr_reg,
  input  logic [DATA_W-1:0] w_data_reg,
  input  logic              w,
  input  logic              clr,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_zero_rd;
  logic              w_byp1, w_byp2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The clear engine and the user write share the single array write port.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_waddr     = w_addr_reg;
    w_wdata     = w_data_reg;
    case (r_state)
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = '0;
        if (clr) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (clr) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_we = w && (w_addr_reg != '0);
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign busy      = (r_state == CLEAR);
  assign w_zero_rd = (r_state == CLEAR) || clr;

`ifdef REGFILE_BYPASS_EN
  assign w_byp1 = w_we && (r_state == RUN) && (w_addr_reg == r_addr_reg1);
  assign w_byp2 = w_we && (r_state == RUN) && (w_addr_reg == r_addr_reg2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_reg1 <= '0;
      r_data_reg2 <= '0;
    end else begin
      if (w_zero_rd || r_addr_reg1 == '0) r_data_reg1 <= '0;
      else if (w_byp1)                    r_data_reg1 <= w_data_reg;
      else                                r_data_reg1 <= r_mem[r_addr_reg1];
      if (w_zero_rd || r_addr_reg2 == '0) r_data_reg2 <= '0;
      else if (w_byp2)                    r_data_reg2 <= w_data_reg;
      else                                r_data_reg2 <= r_mem[r_addr_reg2];
    end
  end

endmodule

// File: tb/tb_regfile_bram.sv
// Directed bench for regfile_bram: expected read data goes through a scoreboard queue.
module tb_regfile_bram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  r_addr_reg1 = '0, r_addr_reg2 = '0, w_addr_reg = '0;
  logic [31:0] r_data_reg1, r_data_reg2;
  logic [31:0] w_data_reg = '0;
  logic        w = 1'b0, clr = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  regfile_bram #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .r_addr_reg1(r_addr_reg1), .r_data_reg1(r_data_reg1),
    .r_addr_reg2(r_addr_reg2), .r_data_reg2(r_data_reg2),
    .w_addr_reg(w_addr_reg), .w_data_reg(w_data_reg),
    .w(w), .clr(clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present read addresses, queue expectations, compare after the edge.
  task automatic step_rd(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2, input string tag);
    r_addr_reg1 = a1;
    r_addr_reg2 = a2;
    q1.push_back(e1);
    q2.push_back(e2);
    @(posedge clk); #1;
    chk({tag, "_p1"}, r_data_reg1, q1.pop_front());
    chk({tag, "_p2"}, r_data_reg2, q2.pop_front());
  endtask

  task automatic do_wr(input logic [4:0] a, input logic [31:0] d);
    w = 1'b1; w_addr_reg = a; w_data_reg = d;
    @(posedge clk); #1;
    w = 1'b0;
  endtask

  // Count edges until busy drops; outputs must stay zero meanwhile.
  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy) begin
        chk({tag, "_out1_during_clear"}, r_data_reg1, 32'h0);
        chk({tag, "_out2_during_clear"}, r_data_reg2, 32'h0);
      end
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'd32);
  endtask

  initial begin
    #12;
    chk("reset_busy", {31'b0, busy}, 32'h1);
    chk("reset_out1", r_data_reg1, 32'h0);
    chk("reset_out2", r_data_reg2, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    r_addr_reg1 = 5'd9;
    r_addr_reg2 = 5'd30;
    wait_clear("initclr");
    for (int i = 0; i < 32; i++) step_rd(5'(i), 5'(31 - i), 32'h0, 32'h0, "init_zero");

    do_wr(5'd5, 32'hDEADBEEF);
    step_rd(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, "r5");
    do_wr(5'd0, 32'h12345678);
    step_rd(5'd0, 5'd0, 32'h0, 32'h0, "r0");

    do_wr(5'd7, 32'h1);
    w = 1'b1; w_addr_reg = 5'd7; w_data_reg = 32'h2;
`ifdef REGFILE_BYPASS_EN
    step_rd(5'd7, 5'd7, 32'h2, 32'h2, "same_cycle_r7");
`else
    step_rd(5'd7, 5'd7, 32'h1, 32'h1, "same_cycle_r7");
`endif
    w = 1'b0;
    step_rd(5'd7, 5'd7, 32'h2, 32'h2, "after_r7");

    for (int i = 1; i < 32; i++) do_wr(5'(i), 32'(i));
    for (int i = 1; i < 32; i++) step_rd(5'(i), 5'(32 - i), 32'(i), 32'(32 - i), "fill");
    r_addr_reg1 = 5'd3; r_addr_reg2 = 5'd31;
    clr = 1'b1; w = 1'b1; w_addr_reg = 5'd3; w_data_reg = 32'h0000AAAA;
    @(posedge clk); #1;
    clr = 1'b0; w = 1'b0;
    chk("clr_busy_now", {31'b0, busy}, 32'h1);
    chk("clr_out1_now", r_data_reg1, 32'h0);
    wait_clear("clr");
    for (int i = 0; i < 32; i++) step_rd(5'(i), 5'(i), 32'h0, 32'h0, "after_clr");

    do_wr(5'd1, 32'h11);
    do_wr(5'd2, 32'h22);
    step_rd(5'd1, 5'd2, 32'h11, 32'h22, "pre_rst");
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out1", r_data_reg1, 32'h0);
    chk("async_rst_out2", r_data_reg2, 32'h0);
    chk("async_rst_busy", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_clear("rerun");
    step_rd(5'd1, 5'd2, 32'h0, 32'h0, "rerun_zero");

    do_wr(5'd4, 32'h44);
    step_rd(5'd4, 5'd4, 32'h44, 32'h44, "pre_clr10");
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midclr_rst_busy", {31'b0, busy}, 32'h1);
    chk("midclr_rst_out1", r_data_reg1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_clear("midclr_rerun");
    do_wr(5'd6, 32'h66);
    step_rd(5'd6, 5'd4, 32'h66, 32'h0, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
